// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: default data width, divider FSM states
// and the divide-by-zero quotient pattern.
package arith_pkg;

  localparam int DATA_WIDTH = 64;

  localparam logic [DATA_WIDTH-1:0] DIV_ZERO_Q = {DATA_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_div_64_sub_ripple.sv
// Ripple-borrow subtractor a - b built from full-adder cells (b inverted, carry-in 1).
module sub_ripple #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] carry_s;

  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic p_s;
    assign p_s          = a[i] ^ ~b[i];
    assign diff[i]      = p_s ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & ~b[i]) | (carry_s[i] & p_s);
  end

  // No carry out of the top cell means a < b.
  assign borrow = ~carry_s[W];

endmodule

// File: rtl/seq_div_64.sv
// Radix-2 restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (sign fix-up around the unsigned core).
module seq_div_64
  import arith_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ZERO_Q   = {WIDTH{DIV_ZERO_Q[0]}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  div_state_e       state_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_by_zero_r;
  logic [CNT_W-1:0] counter_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] divisor_r;

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;
  logic             sub_borrow_s;
  logic             borrow_s;
  logic [WIDTH-1:0] next_rem_s;
  logic [WIDTH-1:0] next_quo_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH-1:0] fin_quo_s;
  logic [WIDTH-1:0] fin_rem_s;

  assign rem_sh_s = {rem_r, quo_r[WIDTH-1]};

  sub_ripple #(.W(WIDTH)) u_sub (
    .a      (rem_sh_s[WIDTH-1:0]),
    .b      (divisor_r),
    .diff   (diff_s),
    .borrow (sub_borrow_s)
  );

`ifdef DIV_SIGNED_EN
  logic neg_q_r;
  logic neg_r_r;

  assign dvd_mag_s = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag_s = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign fin_quo_s = neg_q_r ? -next_quo_s : next_quo_s;
  assign fin_rem_s = neg_r_r ? -next_rem_s : next_rem_s;

  // Operand signs captured at accept for the final fix-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (state_r == IDLE && in_valid) begin
      neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_r <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag_s = dividend;
  assign dvs_mag_s = divisor;
  assign fin_quo_s = next_quo_s;
  assign fin_rem_s = next_rem_s;
`endif

  // A shifted-out 1 means the partial remainder already exceeds any WIDTH-bit divisor.
  always_comb begin
    borrow_s   = sub_borrow_s & ~rem_sh_s[WIDTH];
    next_quo_s = {quo_r[WIDTH-2:0], ~borrow_s};
    if (borrow_s) begin
      next_rem_s = rem_sh_s[WIDTH-1:0];
    end else begin
      next_rem_s = diff_s;
    end
  end

  // Control FSM, iteration datapath and registered result port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      quotient_r    <= {WIDTH{1'b0}};
      remainder_r   <= {WIDTH{1'b0}};
      div_by_zero_r <= 1'b0;
      counter_r     <= {CNT_W{1'b0}};
      rem_r         <= {WIDTH{1'b0}};
      quo_r         <= {WIDTH{1'b0}};
      divisor_r     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            divisor_r <= dvs_mag_s;
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= dvd_mag_s;
            counter_r <= {CNT_W{1'b0}};
            busy_r    <= 1'b1;
            if (divisor == {WIDTH{1'b0}}) begin
              state_r       <= DONE;
              out_valid_r   <= 1'b1;
              quotient_r    <= ZERO_Q;
              remainder_r   <= dividend;
              div_by_zero_r <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          rem_r     <= next_rem_s;
          quo_r     <= next_quo_s;
          counter_r <= counter_r + CNT_ONE;
          if (counter_r == LAST_CNT) begin
            state_r       <= DONE;
            out_valid_r   <= 1'b1;
            quotient_r    <= fin_quo_s;
            remainder_r   <= fin_rem_s;
            div_by_zero_r <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = (state_r == IDLE);
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_seq_div_64.sv
// Self-checking bench for seq_div_64: directed scenarios plus random pairs against
// a plain-arithmetic reference (signed semantics when DIV_SIGNED_EN is defined).
module tb_seq_div_64;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend = 64'd0;
  logic [63:0] divisor = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  seq_div_64 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic dz);
    dz = 1'b0;
    if (b == 64'd0) begin
      q  = ONES;
      r  = a;
      dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == MIN && b == ONES) begin
        q = MIN;
        r = 64'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Runs one operation from IDLE; lat = edges from accept until out_valid is seen.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] q, output logic [63:0] r,
                        output logic dz, output int lat);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, busy, div_by_zero} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL reset_flags: got ov/ir/busy/dz=%b want 0100", {out_valid, in_ready, busy, div_by_zero});
    end
    tests_run++;
    if (quotient !== 64'd0 || remainder !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got q=%h r=%h want 0 0", quotient, remainder);
    end
  endtask

  task automatic test_basic();
    logic [63:0] q, r;
    logic dz;
    int lat;
    in_valid = 1'b1; dividend = 64'd100; divisor = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, in_ready, out_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL basic_running: got busy/ir/ov=%b want 100", {busy, in_ready, out_valid});
    end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    run_op(64'd100, 64'd7, q, r, dz, lat);
    tests_run++;
    if (q !== 64'd14 || r !== 64'd2 || dz !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_100_7: got q=%0d r=%0d dz=%b want 14 2 0", q, r, dz);
    end
    tests_run++;
    if (lat !== 64) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d want 64", lat);
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] q, r;
    logic dz;
    int lat;
    run_op(64'hDEAD_BEEF, 64'd0, q, r, dz, lat);
    tests_run++;
    if (q !== ONES || r !== 64'hDEAD_BEEF || dz !== 1'b1) begin
      tests_failed++;
      $display("FAIL div_zero: got q=%h r=%h dz=%b want all-ones deadbeef 1", q, r, dz);
    end
    // Result is already visible in the cycle right after acceptance.
    tests_run++;
    if (lat !== 0) begin
      tests_failed++;
      $display("FAIL div_zero_latency: got %0d want 0", lat);
    end
  endtask

  task automatic test_extremes();
    logic [63:0] q, r;
    logic dz;
    int lat;
    run_op(ONES, 64'd1, q, r, dz, lat);
    tests_run++;
    if (q !== ONES || r !== 64'd0 || dz !== 1'b0) begin
      tests_failed++;
      $display("FAIL ext_ones_1: got q=%h r=%h dz=%b want all-ones 0 0", q, r, dz);
    end
    run_op(64'd5, 64'd9, q, r, dz, lat);
    tests_run++;
    if (q !== 64'd0 || r !== 64'd5 || dz !== 1'b0) begin
      tests_failed++;
      $display("FAIL ext_5_9: got q=%0d r=%0d dz=%b want 0 5 0", q, r, dz);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] q, r;
    logic dz;
    int lat;
    in_valid = 1'b1; dividend = 64'd1000; divisor = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_timeout: out_valid=%b want 1 within 300 cycles", out_valid);
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = {$urandom, $urandom};
      divisor  = {$urandom, $urandom};
      @(posedge clk); #1;
      tests_run++;
      if (quotient !== 64'd333 || remainder !== 64'd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got q=%0d r=%0d ov=%b ir=%b want 333 1 1 0",
                 i, quotient, remainder, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    run_op(64'd100, 64'd7, q, r, dz, lat);
    tests_run++;
    if (q !== 64'd14 || r !== 64'd2) begin
      tests_failed++;
      $display("FAIL bp_next_op: got q=%0d r=%0d want 14 2", q, r);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] q, r;
    logic dz;
    int lat;
    in_valid = 1'b1; dividend = 64'd1000; divisor = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        quotient !== 64'd0 || remainder !== 64'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_run: got ov=%b ir=%b busy=%b q=%h r=%h want 0 1 0 0 0",
               out_valid, in_ready, busy, quotient, remainder);
    end
    run_op(64'd100, 64'd7, q, r, dz, lat);
    tests_run++;
    if (q !== 64'd14 || r !== 64'd2 || lat !== 64) begin
      tests_failed++;
      $display("FAIL rst_then_op: got q=%0d r=%0d lat=%0d want 14 2 64", q, r, lat);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [63:0] q, r, a, b, eq, er;
    logic dz;
    int lat;
    a = -64'sd100;
    b = 64'd7;
    eq = -64'sd14;
    er = -64'sd2;
    run_op(a, b, q, r, dz, lat);
    tests_run++;
    if (q !== eq || r !== er || dz !== 1'b0) begin
      tests_failed++;
      $display("FAIL signed_m100_7: got q=%h r=%h dz=%b want %h %h 0", q, r, dz, eq, er);
    end
    run_op(MIN, ONES, q, r, dz, lat);
    tests_run++;
    if (q !== MIN || r !== 64'd0 || dz !== 1'b0) begin
      tests_failed++;
      $display("FAIL signed_min_m1: got q=%h r=%h dz=%b want %h 0 0", q, r, dz, MIN);
    end
  endtask
`endif

  task automatic test_random();
    logic [63:0] a, b, q, r, eq, er;
    logic dz, edz;
    int lat;
    for (int i = 0; i < 600; i++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 63);
      case ($urandom_range(0, 7))
        0:       b = 64'd0;
        1, 2:    b = 64'($urandom_range(1, 1000));
        3, 4:    b = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: b = {$urandom, $urandom};
      endcase
      ref_div(a, b, eq, er, edz);
      run_op(a, b, q, r, dz, lat);
      tests_run++;
      if (q !== eq || r !== er || dz !== edz) begin
        tests_failed++;
        $display("FAIL rand[%0d] %h/%h: got q=%h r=%h dz=%b want %h %h %b",
                 i, a, b, q, r, dz, eq, er, edz);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_div_zero();
    test_extremes();
    test_backpressure();
    test_reset_mid_run();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
